// File: rtl/pid_core_param_if.sv
// Sample/result bundle for pid_core_param.
// master drives samples and gains, slave returns ready, result strobe and control output.
interface pid_core_param_if #(
  parameter int W  = 8,
  parameter int KW = 8,
  parameter int CW = 1
);
  logic                 ena;
  logic                 clr_int;
  logic                 in_valid;
  logic                 in_ready;
  logic [CW-1:0]        in_ch;
  logic signed [W-1:0]  e;
  logic [KW-1:0]        kp;
  logic [KW-1:0]        ki;
  logic [KW-1:0]        kd;
  logic                 out_valid;
  logic [CW-1:0]        out_ch;
  logic signed [W-1:0]  u;
  logic                 sat;

  modport master (
    output ena, clr_int, in_valid, in_ch, e, kp, ki, kd,
    input  in_ready, out_valid, out_ch, u, sat
  );

  modport slave (
    input  ena, clr_int, in_valid, in_ch, e, kp, ki, kd,
    output in_ready, out_valid, out_ch, u, sat
  );
endinterface

// File: rtl/pid_core_param.sv
// Multi-channel PID core: P, I, D terms computed one per cycle, then summed, scaled and clamped.
// Latency: out_valid in the cycle after the 4th enabled edge following accept; one sample per 5 cycles.
// Backpressure: in_ready only in IDLE with ena=1 and clr_int=0; ena=0 freezes everything in flight.
module pid_core_param #(
  parameter int  W    = 8,
  parameter int  KW   = 8,
  parameter int  FRAC = 4,
  parameter int  IW   = 16,
  parameter int  NCH  = 2,
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input logic             clk,
  input logic             rst,
  pid_core_param_if.slave bus
);
  // Wide enough that p+i+d never overflows before scaling.
  localparam int S = KW + IW + 3;

  localparam logic [CW:0]         NCH_L = (CW+1)'(NCH);
  localparam logic signed [IW:0]  A_MAX = {2'b00, {(IW-1){1'b1}}};
  localparam logic signed [IW:0]  A_MIN = -A_MAX;
  localparam logic signed [S-1:0] U_MAX = {{(S-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [S-1:0] U_MIN = {{(S-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [2:0] {ST_IDLE, ST_P, ST_I, ST_D, ST_OUT} state_t;

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [W-1:0]  e;
    logic [KW-1:0] kp;
    logic [KW-1:0] ki;
    logic [KW-1:0] kd;
  } smp_t;

  state_t               state_q, state_d;
  smp_t                 smp_q;
  logic signed [IW-1:0] acc    [NCH];
  logic signed [W-1:0]  e_prev [NCH];
  logic [NCH-1:0]       sat_pos, sat_neg;
  logic signed [S-1:0]  p_q, i_q, d_q;
  logic                 out_valid_q, sat_q;
  logic [CW-1:0]        out_ch_q;
  logic signed [W-1:0]  u_q;

  logic                 accept, ch_ok, hold, hi, lo;
  logic signed [W-1:0]  e_q, e_prev_cur, u_next;
  logic signed [IW-1:0] acc_cur, acc_new;
  logic signed [IW:0]   acc_sum;
  logic signed [W:0]    dif;
  logic signed [S-1:0]  e_x, kp_x, ki_x, kd_x, acc_x, dif_x, sum_x, s_x;

  assign bus.in_ready  = (state_q == ST_IDLE) && bus.ena && !bus.clr_int && !rst;
  assign accept        = bus.in_valid && bus.in_ready;
  assign ch_ok         = {1'b0, bus.in_ch} < NCH_L;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.u         = u_q;
  assign bus.sat       = sat_q;

  always_comb begin
    state_d = state_q;
    if (bus.ena) begin
      if (bus.clr_int) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: if (accept && ch_ok) state_d = ST_P;
          ST_P:    state_d = ST_I;
          ST_I:    state_d = ST_D;
          ST_D:    state_d = ST_OUT;
          ST_OUT:  state_d = ST_IDLE;
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  assign e_q        = $signed(smp_q.e);
  assign e_prev_cur = e_prev[smp_q.ch];
  assign acc_cur    = acc[smp_q.ch];
  assign acc_sum    = {acc_cur[IW-1], acc_cur} + {{(IW+1-W){e_q[W-1]}}, e_q};

  // Anti-windup: freeze the integrator while pushing further into the last saturation.
  assign hold = (sat_pos[smp_q.ch] && !e_q[W-1] && (e_q != '0)) ||
                (sat_neg[smp_q.ch] && e_q[W-1]);

  always_comb begin
    acc_new = acc_cur;
    if (!hold) begin
      if (acc_sum > A_MAX)      acc_new = A_MAX[IW-1:0];
      else if (acc_sum < A_MIN) acc_new = A_MIN[IW-1:0];
      else                      acc_new = acc_sum[IW-1:0];
    end
  end

  assign dif   = {e_q[W-1], e_q} - {e_prev_cur[W-1], e_prev_cur};
  assign e_x   = {{(S-W){e_q[W-1]}}, e_q};
  assign acc_x = {{(S-IW){acc_new[IW-1]}}, acc_new};
  assign dif_x = {{(S-W-1){dif[W]}}, dif};
  assign kp_x  = {{(S-KW){1'b0}}, smp_q.kp};
  assign ki_x  = {{(S-KW){1'b0}}, smp_q.ki};
  assign kd_x  = {{(S-KW){1'b0}}, smp_q.kd};

  assign sum_x  = p_q + i_q + d_q;
  assign s_x    = sum_x >>> FRAC;
  assign hi     = s_x > U_MAX;
  assign lo     = s_x < U_MIN;
  assign u_next = hi ? U_MAX[W-1:0] : (lo ? U_MIN[W-1:0] : s_x[W-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_q       <= '0;
      p_q         <= '0;
      i_q         <= '0;
      d_q         <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      u_q         <= '0;
      sat_q       <= 1'b0;
      sat_pos     <= '0;
      sat_neg     <= '0;
      for (int c = 0; c < NCH; c++) begin
        acc[c]    <= '0;
        e_prev[c] <= '0;
      end
    end else begin
      // Strobe drops even when stalled so a result is never reported twice.
      out_valid_q <= 1'b0;
      if (bus.ena) begin
        if (bus.clr_int) begin
          sat_pos <= '0;
          sat_neg <= '0;
          for (int c = 0; c < NCH; c++) begin
            acc[c]    <= '0;
            e_prev[c] <= '0;
          end
        end else begin
          case (state_q)
            ST_IDLE: if (accept) smp_q <= '{ch: bus.in_ch, e: bus.e, kp: bus.kp, ki: bus.ki, kd: bus.kd};
            ST_P:    p_q <= kp_x * e_x;
            ST_I: begin
              acc[smp_q.ch] <= acc_new;
              i_q           <= ki_x * acc_x;
            end
            ST_D:    d_q <= kd_x * dif_x;
            ST_OUT: begin
              out_valid_q      <= 1'b1;
              out_ch_q         <= smp_q.ch;
              u_q              <= u_next;
              sat_q            <= hi || lo;
              sat_pos[smp_q.ch] <= hi;
              sat_neg[smp_q.ch] <= lo;
              e_prev[smp_q.ch]  <= e_q;
            end
            default: ;
          endcase
        end
      end
    end
  end
endmodule
